line_mem_responder: RTL

// - Main-memory responder for the instruction and data caches. It serves line fills and dirty-line writebacks.
// - Sits below icache/dcache at the far end of their miss interface. Takes one request at a time.
// - Each request completes after a fixed latency, which models the long memory access the pipeline stalls on.

---
 rtl/line_mem_responder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/line_mem_responder.sv
// Purpose  : main-memory line responder below the icache/dcache miss ports; one request at a time.
// Latency  : request accepted on edge T gives a one-cycle resp pulse after edge T+MEM_LATENCY.
// Backpres.: both req_ready drop while a request is in flight; responses cannot be stalled.
//
// Ports
//   clk, reset                  clock (rising edge) and asynchronous active-high reset
//   ic_req_valid/addr/ready     icache line-read request
//   ic_resp_valid/data          icache read response pulse
//   dc_req_valid/we/addr/wdata  dcache line read (we=0) or writeback (we=1)
//   dc_req_ready                dcache request accept
//   dc_resp_valid/data          dcache read data, or write ack with zero data
//
// Build option
//   MEM_RR_ARB_EN  defined   : round-robin arbitration between icache and dcache
//                  undefined : fixed priority, dcache wins every conflict
//
// DEPTH must be a power of two so that the line index is simply the low address
// bits above the 16-byte offset (which is the same as line number mod DEPTH).
// The line array is not touched by reset; it starts out all-zero.

module line_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 128,
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    // icache port
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    output logic [LINE_W-1:0] ic_resp_data,
    // dcache port
    input  logic              dc_req_valid,
    input  logic              dc_req_we,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [LINE_W-1:0] dc_req_wdata,
    output logic              dc_req_ready,
    output logic              dc_resp_valid,
    output logic [LINE_W-1:0] dc_resp_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Zero latency is meaningless; clamp into the 1..255 range the counter can hold.
    localparam int LAT_C = (MEM_LATENCY < 1)   ? 1   :
                           (MEM_LATENCY > 255) ? 255 : MEM_LATENCY;
    localparam logic [7:0] CNT_LOAD = 8'(LAT_C - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_nxt;
    logic               w_accept;

    // Latched request
    logic               r_port_dc;
    logic               r_we;
    logic [IDX_W-1:0]   r_idx;
    logic [LINE_W-1:0]  r_wdata;

    // Registered response outputs
    logic               r_ic_resp_valid;
    logic [LINE_W-1:0]  r_ic_resp_data;
    logic               r_dc_resp_valid;
    logic [LINE_W-1:0]  r_dc_resp_data;

    // Line storage; initial value applies at time 0 only, reset leaves it alone.
    logic [LINE_W-1:0]  r_mem [DEPTH] = '{default: '0};

    logic [IDX_W-1:0]   w_ic_idx;
    logic [IDX_W-1:0]   w_dc_idx;
    logic               w_req_any;
    logic               w_grant_dc;
    logic [LINE_W-1:0]  w_rd_line;
    logic               w_unused_addr;

    assign w_ic_idx = ic_req_addr[IDX_W+3:4];
    assign w_dc_idx = dc_req_addr[IDX_W+3:4];

    // Offset bits and the wrapped-away upper address bits carry no information here.
    assign w_unused_addr = ^{ic_req_addr[3:0], ic_req_addr[ADDR_W-1:IDX_W+4],
                             dc_req_addr[3:0], dc_req_addr[ADDR_W-1:IDX_W+4]};

    assign w_req_any = ic_req_valid | dc_req_valid;

    //------------------------------------------------------------------
    // Arbitration
    //------------------------------------------------------------------
`ifdef MEM_RR_ARB_EN
    // 1 = dcache got the most recent grant. Resets to "icache" so that the
    // first conflict goes to dcache.
    logic r_last_dc;

    assign w_grant_dc = dc_req_valid & (~ic_req_valid | ~r_last_dc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_dc <= 1'b0;
        end else if (w_accept) begin
            r_last_dc <= w_grant_dc;
        end
    end
`else
    // dcache misses block loads/stores, so they always take priority.
    assign w_grant_dc = dc_req_valid;
`endif

    //------------------------------------------------------------------
    // FSM
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter reaches zero as the FSM enters RESP. RESP is the cycle in
    // which the array is accessed; the response registers load on the edge
    // that leaves RESP, so the pulse is visible together with ready in the
    // following IDLE cycle. This gives exactly MEM_LATENCY edges from accept
    // to pulse and lets the next request be accepted on the edge after it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = (CNT_LOAD == 8'd0) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt <= 8'd1) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt   = r_cnt - 8'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ic_req_ready = (r_state == S_IDLE);
    assign dc_req_ready = (r_state == S_IDLE);

    //------------------------------------------------------------------
    // Request latch
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_port_dc <= 1'b0;
            r_we      <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
        end else if (w_accept) begin
            r_port_dc <= w_grant_dc;
            r_we      <= w_grant_dc & dc_req_we;
            r_idx     <= w_grant_dc ? w_dc_idx : w_ic_idx;
            r_wdata   <= dc_req_wdata;
        end
    end

    //------------------------------------------------------------------
    // Array access and response
    //------------------------------------------------------------------
    assign w_rd_line = r_mem[r_idx];

    // Reset forces the FSM out of RESP immediately, so a request interrupted
    // by reset never writes the array.
    always_ff @(posedge clk) begin
        if ((r_state == S_RESP) && r_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    // Data is cleared whenever no pulse is issued, so a write ack returns zero
    // and the idle bus stays quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ic_resp_valid <= 1'b0;
            r_ic_resp_data  <= '0;
            r_dc_resp_valid <= 1'b0;
            r_dc_resp_data  <= '0;
        end else begin
            r_ic_resp_valid <= (r_state == S_RESP) & ~r_port_dc;
            r_dc_resp_valid <= (r_state == S_RESP) &  r_port_dc;
            r_ic_resp_data  <= ((r_state == S_RESP) & ~r_port_dc)        ? w_rd_line : '0;
            r_dc_resp_data  <= ((r_state == S_RESP) & r_port_dc & ~r_we) ? w_rd_line : '0;
        end
    end

    assign ic_resp_valid = r_ic_resp_valid;
    assign ic_resp_data  = r_ic_resp_data;
    assign dc_resp_valid = r_dc_resp_valid;
    assign dc_resp_data  = r_dc_resp_data;

endmodule
